// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes SPI register/memory strobes into a small CSR file
// (ID, CTRL, STATUS, SCRATCH) driving the PE pipeline, plus a memory window
// forwarded to an SRAM-style req/gnt port with variable read latency.
// Optional feature: define SPI_BRIDGE_TIMEOUT_EN to abort a memory read that
// gets no mem_rvalid within TIMEOUT WAIT cycles (responds 0xEE, sets ERR).
module spi_reg_bridge #(
   parameter int          DW      = 8,
   parameter int          AW      = 16,
   parameter int          MEM_AW  = 12,
   parameter logic [DW-1:0] ID_VAL = 8'hA5,
   parameter int          TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     addr,
   input  logic [DW-1:0]     wdata,
   input  logic              wen,
   input  logic              ren,
   output logic [DW-1:0]     rdata,
   output logic              rvalid,
   output logic              pe_start,
   output logic              pe_run,
   input  logic              pe_busy,
   input  logic              pe_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DW-1:0]     mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                pe_start_q, pe_start_d;
   logic                run_q, run_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                ovr_q, ovr_d;
   logic [DW-1:0]       scratch_q, scratch_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
   // memory response parked for one cycle when it collides with a register read
   logic                pend_q, pend_d;
   logic [DW-1:0]       pend_data_q, pend_data_d;

   logic                rd_eff, acc;
   logic                is_id, is_ctrl, is_stat, is_scr, is_win, is_unm;
   logic [DW-1:0]       reg_rdata;
   logic                mem_rsp_v;
   logic [DW-1:0]       mem_rsp_data;
   logic                timeout_hit;

`ifdef SPI_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
   logic                unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   // A simultaneous read is dropped in favour of the write.
   assign rd_eff  = ren & ~wen;
   assign acc     = wen | rd_eff;
   assign is_id   = (addr == AW'(0));
   assign is_ctrl = (addr == AW'(1));
   assign is_stat = (addr == AW'(2));
   assign is_scr  = (addr == AW'(3));
   assign is_win  = (addr[AW-1:MEM_AW] == (AW-MEM_AW)'(1));
   assign is_unm  = ~(is_id | is_ctrl | is_stat | is_scr | is_win);

   // Register read mux; unmapped addresses read as zero.
   always_comb begin
      reg_rdata = '0;
      if (is_id) begin
         reg_rdata = ID_VAL;
      end else if (is_ctrl) begin
         reg_rdata[1] = run_q;
      end else if (is_stat) begin
         reg_rdata[3:0] = {ovr_q, err_q, done_q, pe_busy};
      end else if (is_scr) begin
         reg_rdata = scratch_q;
      end
   end

   // Memory FSM: next state, request fields and memory-side response.
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_rsp_v    = 1'b0;
      mem_rsp_data = mem_rdata;
      timeout_hit  = 1'b0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      cnt_d        = '0;
`endif
      case (state_q)
         IDLE: begin
            if (acc && is_win) begin
               state_d     = REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = wen;
               mem_addr_d  = addr[MEM_AW-1:0];
               mem_wdata_d = wdata;
            end
         end
         REQ: begin
            // mem_rvalid is deliberately not looked at on the grant cycle
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = mem_we_q ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               mem_rsp_v = 1'b1;
               state_d   = IDLE;
`ifdef SPI_BRIDGE_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               mem_rsp_v    = 1'b1;
               mem_rsp_data = DW'(8'hEE);
               timeout_hit  = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register file updates, sticky status bits and response arbitration.
   always_comb begin
      run_d       = run_q;
      scratch_d   = scratch_q;
      pe_start_d  = wen & is_ctrl & wdata[0];
      rvalid_d    = 1'b0;
      rdata_d     = rdata_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      if (wen && is_ctrl) run_d = wdata[1];
      if (wen && is_scr)  scratch_d = wdata;
      // set wins over a same-cycle write-1-to-clear
      done_d = pe_done | (done_q & ~(wen & is_stat & wdata[1]));
      err_d  = (acc & is_unm) | timeout_hit | (err_q & ~(wen & is_stat & wdata[2]));
      ovr_d  = (ren & wen) | (acc & is_win & (state_q != IDLE))
             | (ovr_q & ~(wen & is_stat & wdata[3]));
      // register reads go first; a colliding memory response slips one cycle
      if (rd_eff && !is_win) begin
         rvalid_d = 1'b1;
         rdata_d  = reg_rdata;
         if (mem_rsp_v) begin
            pend_d      = 1'b1;
            pend_data_d = mem_rsp_data;
         end
      end else if (pend_q) begin
         rvalid_d = 1'b1;
         rdata_d  = pend_data_q;
         pend_d   = 1'b0;
      end else if (mem_rsp_v) begin
         rvalid_d = 1'b1;
         rdata_d  = mem_rsp_data;
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         pe_start_q  <= 1'b0;
         run_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
         scratch_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         pe_start_q  <= pe_start_d;
         run_q       <= run_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
         scratch_q   <= scratch_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
`ifdef SPI_BRIDGE_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign pe_start  = pe_start_q;
   assign pe_run    = run_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: register vectors from a table, then
// hand-written memory handshake, overrun/collision and (optional) timeout runs.
module tb_spi_reg_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        wen, ren;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        pe_start, pe_run, pe_busy, pe_done;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [7:0]  mem_rdata;

   int checks = 0;
   int errors = 0;

   spi_reg_bridge dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
      .rdata(rdata), .rvalid(rvalid), .pe_start(pe_start), .pe_run(pe_run),
      .pe_busy(pe_busy), .pe_done(pe_done), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [15:0] a;
      logic [7:0]  d;
      logic        busy;
      logic        ev;   // expected rvalid
      logic [7:0]  ed;   // expected rdata (when ev)
      logic        es;   // expected pe_start
      logic        er;   // expected pe_run
   } vec_t;

   vec_t tbl[24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", nm, act);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic we, input logic re, input logic [15:0] a,
                         input logic [7:0] d);
      wen = we; ren = re; addr = a; wdata = d;
      step();
      wen = 1'b0; ren = 1'b0;
   endtask

   initial begin
      int n;
      tbl[0]  = '{1'b0,1'b1,16'h0000,8'h00,1'b0, 1'b1,8'hA5, 1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h00, 1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b0,16'h0003,8'h5C,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b1,16'h0003,8'h00,1'b0, 1'b1,8'h5C, 1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b0,16'h0001,8'h03,1'b0, 1'b0,8'h00, 1'b1,1'b1};
      tbl[5]  = '{1'b0,1'b1,16'h0001,8'h00,1'b0, 1'b1,8'h02, 1'b0,1'b1};
      tbl[6]  = '{1'b0,1'b1,16'h0002,8'h00,1'b1, 1'b1,8'h01, 1'b0,1'b1};
      tbl[7]  = '{1'b0,1'b1,16'h4000,8'h00,1'b0, 1'b1,8'h00, 1'b0,1'b1};
      tbl[8]  = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h04, 1'b0,1'b1};
      tbl[9]  = '{1'b1,1'b0,16'h0002,8'h04,1'b0, 1'b0,8'h00, 1'b0,1'b1};
      tbl[10] = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h00, 1'b0,1'b1};
      tbl[11] = '{1'b1,1'b0,16'h0001,8'h00,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[12] = '{1'b0,1'b1,16'h0001,8'h00,1'b0, 1'b1,8'h00, 1'b0,1'b0};
      tbl[13] = '{1'b1,1'b0,16'h0000,8'hFF,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[14] = '{1'b0,1'b1,16'h0000,8'h00,1'b0, 1'b1,8'hA5, 1'b0,1'b0};
      tbl[15] = '{1'b1,1'b1,16'h0003,8'h11,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[16] = '{1'b0,1'b1,16'h0003,8'h00,1'b0, 1'b1,8'h11, 1'b0,1'b0};
      tbl[17] = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h08, 1'b0,1'b0};
      tbl[18] = '{1'b1,1'b0,16'h0002,8'h08,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[19] = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h00, 1'b0,1'b0};
      tbl[20] = '{1'b1,1'b0,16'h0005,8'h12,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[21] = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h04, 1'b0,1'b0};
      tbl[22] = '{1'b1,1'b0,16'h0002,8'h04,1'b0, 1'b0,8'h00, 1'b0,1'b0};
      tbl[23] = '{1'b0,1'b1,16'h0002,8'h00,1'b0, 1'b1,8'h00, 1'b0,1'b0};

      rst = 1'b1; addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;
      pe_busy = 1'b0; pe_done = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rvalid", 32'(rvalid), 32'd0);
      chk("reset rdata", 32'(rdata), 32'h00);
      chk("reset pe_start", 32'(pe_start), 32'd0);
      chk("reset pe_run", 32'(pe_run), 32'd0);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'h000);
      rst = 1'b0;
      step();

      // register vectors
      for (int i = 0; i < 24; i++) begin
         pe_busy = tbl[i].busy;
         access(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d);
         pe_busy = 1'b0;
         chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].ed));
         chk($sformatf("vec%0d pe_start", i), 32'(pe_start), 32'(tbl[i].es));
         chk($sformatf("vec%0d pe_run", i), 32'(pe_run), 32'(tbl[i].er));
         step();
      end

      // DONE sticky, set wins over same-cycle W1C, then clears
      pe_done = 1'b1; step(); pe_done = 1'b0;
      access(1'b0, 1'b1, 16'h0002, 8'h00);
      chk("done set", 32'(rdata), 32'h02);
      pe_done = 1'b1;
      access(1'b1, 1'b0, 16'h0002, 8'h02);
      pe_done = 1'b0;
      access(1'b0, 1'b1, 16'h0002, 8'h00);
      chk("done set beats w1c", 32'(rdata), 32'h02);
      access(1'b1, 1'b0, 16'h0002, 8'h02);
      access(1'b0, 1'b1, 16'h0002, 8'h00);
      chk("done w1c", 32'(rdata), 32'h00);

      // memory write, grant after 3 request cycles
      access(1'b1, 1'b0, 16'h1234, 8'h77);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mw req c%0d", i), 32'(mem_req), 32'd1);
         chk($sformatf("mw addr c%0d", i), 32'(mem_addr), 32'h234);
         chk($sformatf("mw we c%0d", i), 32'(mem_we), 32'd1);
         chk($sformatf("mw wdata c%0d", i), 32'(mem_wdata), 32'h77);
         mem_gnt = (i == 2);
         step();
      end
      mem_gnt = 1'b0;
      chk("mw req dropped", 32'(mem_req), 32'd0);
      chk("mw no rvalid", 32'(rvalid), 32'd0);

      // memory read; rvalid on the grant cycle must be ignored
      access(1'b0, 1'b1, 16'h1010, 8'h00);
      chk("mr req", 32'(mem_req), 32'd1);
      chk("mr we", 32'(mem_we), 32'd0);
      chk("mr addr", 32'(mem_addr), 32'h010);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h55;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("mr req dropped", 32'(mem_req), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mr wait c%0d rvalid", i), 32'(rvalid), 32'd0);
         step();
      end
      mem_rvalid = 1'b1; mem_rdata = 8'h9A;
      step();
      mem_rvalid = 1'b0;
      chk("mr rvalid", 32'(rvalid), 32'd1);
      chk("mr rdata", 32'(rdata), 32'h9A);
      step();
      chk("mr rvalid one cycle", 32'(rvalid), 32'd0);

      // overrun while in WAIT, then register read colliding with memory data
      access(1'b0, 1'b1, 16'h1000, 8'h00);
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      access(1'b0, 1'b1, 16'h1001, 8'h00);
      chk("ovr dropped rvalid", 32'(rvalid), 32'd0);
      chk("ovr no new req", 32'(mem_req), 32'd0);
      ren = 1'b1; addr = 16'h0003; mem_rvalid = 1'b1; mem_rdata = 8'h3C;
      step();
      ren = 1'b0; mem_rvalid = 1'b0;
      chk("collide reg rvalid", 32'(rvalid), 32'd1);
      chk("collide reg rdata", 32'(rdata), 32'h11);
      step();
      chk("collide mem rvalid", 32'(rvalid), 32'd1);
      chk("collide mem rdata", 32'(rdata), 32'h3C);
      step();
      chk("collide idle", 32'(rvalid), 32'd0);
      access(1'b0, 1'b1, 16'h0002, 8'h00);
      chk("ovr status", 32'(rdata), 32'h08);
      access(1'b1, 1'b0, 16'h0002, 8'h0E);

`ifdef SPI_BRIDGE_TIMEOUT_EN
      access(1'b0, 1'b1, 16'h1000, 8'h00);
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (rvalid) begin
            n = i;
            break;
         end
      end
      chk("timeout cycles", 32'(n), 32'd15);
      chk("timeout rdata", 32'(rdata), 32'hEE);
      mem_rvalid = 1'b1; mem_rdata = 8'h44;
      step();
      mem_rvalid = 1'b0;
      chk("late rvalid c0", 32'(rvalid), 32'd0);
      step();
      chk("late rvalid c1", 32'(rvalid), 32'd0);
      access(1'b0, 1'b1, 16'h0002, 8'h00);
      chk("timeout err", 32'(rdata), 32'h04);
`else
      n = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
